// File: rtl/user_pkg.sv
// Shared user-domain definitions: scratchpad placement, error pattern,
// demux port assignment and the response tuple carried by the response queue.
package user_pkg;

    localparam logic [31:0] ScratchpadBase        = 32'h0001_0000;
    localparam int unsigned ScratchpadWords       = 64;
    localparam logic [31:0] ScratchpadErrData     = 32'hBADCAB1E;
    localparam int unsigned ScratchpadMaxIdWidth  = 8;

    // Demux port index and address rule used by user_addr_map.
    localparam int unsigned UserDemuxScratchpadIdx = 1;
    localparam logic [31:0] ScratchpadEnd          = ScratchpadBase + ScratchpadWords * 4;

    typedef struct packed {
        logic [31:0]                     rdata;
        logic [ScratchpadMaxIdWidth-1:0] rid;
        logic                            err;
    } scratchpad_rsp_t;

endpackage

// File: rtl/user_obi_rsp_fifo.sv
// In-order response queue for user-domain OBI subordinates.
// Push is ignored when full, pop is ignored when empty; head is the oldest entry.
module user_obi_rsp_fifo #(
    parameter int unsigned Depth = 2,
    parameter type         T     = logic [7:0]
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic i_push,
    input  T     i_data,
    input  logic i_pop,
    output logic o_full,
    output logic o_empty,
    output T     o_head
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    T               r_mem [Depth];
    logic [PtrW-1:0] r_wptr;
    logic [PtrW-1:0] r_rptr;
    logic [CntW-1:0] r_count;

    logic            w_push_ok;
    logic            w_pop_ok;
    logic [CntW-1:0] w_count_nxt;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        if (ptr == PtrW'(Depth - 1)) begin
            return '0;
        end
        return ptr + PtrW'(1);
    endfunction

    assign o_full    = (r_count == CntW'(Depth));
    assign o_empty   = (r_count == '0);
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;
    assign o_head    = r_mem[r_rptr];

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push_ok, w_pop_ok})
            2'b10:   w_count_nxt = r_count + CntW'(1);
            2'b01:   w_count_nxt = r_count - CntW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= ptr_inc(r_wptr);
            end
            if (w_pop_ok) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            r_count <= w_count_nxt;
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= i_data;
        end
    end

endmodule

// File: rtl/user_obi_scratchpad.sv
// OBI subordinate backed by a word-addressed scratchpad; reads and byte-enabled
// writes are answered in order through a bounded response queue.
module user_obi_scratchpad
    import user_pkg::*;
#(
    parameter int unsigned          AddrWidth   = 32,
    parameter int unsigned          DataWidth   = 32,
    parameter int unsigned          IdWidth     = 1,
    parameter logic [AddrWidth-1:0] BaseAddr    = AddrWidth'(ScratchpadBase),
    parameter int unsigned          NumWords    = 64,
    parameter int unsigned          NumMaxTrans = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   obi_req_i,
    output logic                   obi_gnt_o,
    input  logic [AddrWidth-1:0]   obi_addr_i,
    input  logic                   obi_we_i,
    input  logic [DataWidth/8-1:0] obi_be_i,
    input  logic [DataWidth-1:0]   obi_wdata_i,
    input  logic [IdWidth-1:0]     obi_aid_i,
    output logic                   obi_rvalid_o,
    input  logic                   obi_rready_i,
    output logic [DataWidth-1:0]   obi_rdata_o,
    output logic [IdWidth-1:0]     obi_rid_o,
    output logic                   obi_err_o
);

    localparam int unsigned IdxW     = $clog2(NumWords);
    localparam int unsigned NumBytes = DataWidth / 8;

    logic [AddrWidth-1:0] w_off;
    logic                 w_in_range;
    logic [IdxW-1:0]      w_idx;
    logic                 w_accept;
    logic                 w_wr_en;
    logic [DataWidth-1:0] w_rd_word;
    scratchpad_rsp_t      w_push_rsp;
    scratchpad_rsp_t      w_head;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_rvalid;
    logic                 w_pop;
    logic                 w_unused;

    // Addresses below BaseAddr wrap to a huge offset and fall out of range.
    assign w_off      = obi_addr_i - BaseAddr;
    assign w_in_range = (w_off < AddrWidth'(NumWords * 4));
    assign w_idx      = w_off[IdxW+1:2];

    assign obi_gnt_o = obi_req_i & ~rst_i & ~w_full;
    assign w_accept  = obi_req_i & obi_gnt_o;
    assign w_wr_en   = w_accept & obi_we_i & w_in_range;

    // One storage lane per byte so each enable writes its own array.
    for (genvar gi = 0; gi < NumBytes; gi++) begin : g_lane
        logic [7:0] r_lane [NumWords];

        always_ff @(posedge clk_i) begin
            if (w_wr_en && obi_be_i[gi]) begin
                r_lane[w_idx] <= obi_wdata_i[gi*8 +: 8];
            end
        end

        assign w_rd_word[gi*8 +: 8] = r_lane[w_idx];
    end

    always_comb begin
        w_push_rsp       = '0;
        w_push_rsp.rid   = ScratchpadMaxIdWidth'(obi_aid_i);
        if (!w_in_range) begin
            w_push_rsp.rdata = ScratchpadErrData;
            w_push_rsp.err   = 1'b1;
        end else if (obi_we_i) begin
            w_push_rsp.rdata = '0;
        end else begin
            w_push_rsp.rdata = w_rd_word;
        end
    end

    user_obi_rsp_fifo #(
        .Depth (NumMaxTrans),
        .T     (scratchpad_rsp_t)
    ) u_rsp_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_push  (w_accept),
        .i_data  (w_push_rsp),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    assign w_rvalid     = ~w_empty & ~rst_i;
    assign w_pop        = w_rvalid & obi_rready_i;
    assign obi_rvalid_o = w_rvalid;
    assign obi_rdata_o  = w_rvalid ? DataWidth'(w_head.rdata) : '0;
    assign obi_rid_o    = w_rvalid ? IdWidth'(w_head.rid) : '0;
    assign obi_err_o    = w_rvalid & w_head.err;

    assign w_unused = ^{w_off[1:0], w_off[AddrWidth-1:IdxW+2], w_head.rid};

endmodule

// File: tb/tb_user_obi_scratchpad.sv
// Directed bench for user_obi_scratchpad: write/read, byte enables, range errors,
// back-pressure, capture-at-accept and mid-operation reset.
module tb_user_obi_scratchpad;
    import user_pkg::*;

    localparam logic [31:0] Base = ScratchpadBase;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [0:0]  aid;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [0:0]  rid;
    logic        err;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    user_obi_scratchpad dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .obi_req_i    (req),
        .obi_gnt_o    (gnt),
        .obi_addr_i   (addr),
        .obi_we_i     (we),
        .obi_be_i     (be),
        .obi_wdata_i  (wdata),
        .obi_aid_i    (aid),
        .obi_rvalid_o (rvalid),
        .obi_rready_i (rready),
        .obi_rdata_o  (rdata),
        .obi_rid_o    (rid),
        .obi_err_o    (err)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_asserts++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end else begin
            $display("ok   %s: %08h", tag, act);
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic xact(input logic w, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] d, input logic id);
        int n = 0;
        req = 1'b1; we = w; addr = a; be = b; wdata = d; aid = id;
        @(negedge clk);
        while (!gnt && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!gnt) check("gnt_timeout", 32'(gnt), 32'd1);
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    // Expects rready high; waits for the response, checks it, lets it pop.
    task automatic get_rsp(input string tag, input logic [31:0] ed, input logic eid,
                           input logic eerr, output int waits);
        int n = 0;
        @(negedge clk);
        while (!rvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        waits = n;
        check({tag, "_rvalid"}, 32'(rvalid), 32'd1);
        check({tag, "_rdata"},  rdata, ed);
        check({tag, "_rid"},    32'(rid), 32'(eid));
        check({tag, "_err"},    32'(err), 32'(eerr));
        @(posedge clk); #1;
    endtask

    initial begin
        int w;
        rst = 1'b1; req = 1'b1; we = 1'b0; addr = Base; be = 4'hF;
        wdata = '0; aid = '0; rready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_gnt",    32'(gnt),    32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rdata",  rdata,       32'd0);
        @(posedge clk); #1;
        rst = 1'b0; req = 1'b0;

        // Write then read back
        xact(1'b1, Base + 32'h10, 4'hF, 32'hDEADBEEF, 1'b0);
        get_rsp("wr10", 32'h0, 1'b0, 1'b0, w);
        xact(1'b0, Base + 32'h10, 4'hF, 32'h0, 1'b1);
        get_rsp("rd10", 32'hDEADBEEF, 1'b1, 1'b0, w);
        check("rd_latency", 32'(w), 32'd0);

        // Byte enables
        xact(1'b1, Base + 32'h4, 4'hF, 32'h11223344, 1'b0);
        get_rsp("be_wr1", 32'h0, 1'b0, 1'b0, w);
        xact(1'b1, Base + 32'h4, 4'b0101, 32'hAABBCCDD, 1'b1);
        get_rsp("be_wr2", 32'h0, 1'b1, 1'b0, w);
        xact(1'b0, Base + 32'h4, 4'hF, 32'h0, 1'b0);
        get_rsp("be_rd", 32'h11BB33DD, 1'b0, 1'b0, w);

        // Out of range on both sides
        xact(1'b0, Base + 32'd256, 4'hF, 32'h0, 1'b1);
        get_rsp("oor_hi", 32'hBADCAB1E, 1'b1, 1'b1, w);
        xact(1'b0, Base - 32'd4, 4'hF, 32'h0, 1'b0);
        get_rsp("oor_lo", 32'hBADCAB1E, 1'b0, 1'b1, w);
        xact(1'b1, Base + 32'd256, 4'hF, 32'h12345678, 1'b1);
        get_rsp("oor_wr", 32'hBADCAB1E, 1'b1, 1'b1, w);
        xact(1'b0, Base + 32'h10, 4'hF, 32'h0, 1'b0);
        get_rsp("oor_after", 32'hDEADBEEF, 1'b0, 1'b0, w);

        // Back-pressure: three back-to-back reads against a depth-2 queue
        rready = 1'b0;
        req = 1'b1; we = 1'b0; be = 4'hF; addr = Base + 32'h10; aid = 1'b0;
        @(negedge clk); check("bp_gnt0", 32'(gnt), 32'd1);
        @(posedge clk); #1; addr = Base + 32'h4; aid = 1'b1;
        @(negedge clk); check("bp_gnt1", 32'(gnt), 32'd1);
        @(posedge clk); #1; addr = Base + 32'h10; aid = 1'b0;
        @(negedge clk);
        check("bp_gnt_full", 32'(gnt),    32'd0);
        check("bp_hold_rv",  32'(rvalid), 32'd1);
        check("bp_hold_rid", 32'(rid),    32'd0);
        @(posedge clk); #1; rready = 1'b1;
        @(negedge clk);
        check("bp_gnt_pop",   32'(gnt), 32'd0);
        check("bp_rsp0_rid",  32'(rid), 32'd0);
        check("bp_rsp0_data", rdata,    32'hDEADBEEF);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_gnt_after", 32'(gnt), 32'd1);
        check("bp_rsp1_rid",  32'(rid), 32'd1);
        check("bp_rsp1_data", rdata,    32'h11BB33DD);
        @(posedge clk); #1; req = 1'b0;
        @(negedge clk);
        check("bp_rsp2_rv",   32'(rvalid), 32'd1);
        check("bp_rsp2_rid",  32'(rid),    32'd0);
        check("bp_rsp2_data", rdata,       32'hDEADBEEF);
        @(posedge clk); #1;
        @(negedge clk); check("bp_drained", 32'(rvalid), 32'd0);
        @(posedge clk); #1;

        // Read data captured at accept
        xact(1'b1, Base + 32'h14, 4'hF, 32'h5, 1'b0);
        get_rsp("cap_init", 32'h0, 1'b0, 1'b0, w);
        rready = 1'b0;
        xact(1'b0, Base + 32'h14, 4'hF, 32'h0, 1'b0);
        xact(1'b1, Base + 32'h14, 4'hF, 32'h99, 1'b1);
        rready = 1'b1;
        get_rsp("cap_rd", 32'h5, 1'b0, 1'b0, w);
        get_rsp("cap_wr", 32'h0, 1'b1, 1'b0, w);
        xact(1'b0, Base + 32'h14, 4'hF, 32'h0, 1'b1);
        get_rsp("cap_new", 32'h99, 1'b1, 1'b0, w);

        // Mid-operation reset with two responses queued
        xact(1'b1, Base + 32'h1C, 4'hF, 32'h77, 1'b0);
        get_rsp("mr_init", 32'h0, 1'b0, 1'b0, w);
        rready = 1'b0;
        xact(1'b0, Base + 32'h1C, 4'hF, 32'h0, 1'b0);
        xact(1'b0, Base + 32'h14, 4'hF, 32'h0, 1'b1);
        @(negedge clk); check("mr_queued", 32'(rvalid), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1; req = 1'b1; we = 1'b1; addr = Base + 32'h1C; be = 4'hF; wdata = 32'hFFFFFFFF;
        @(negedge clk);
        check("mr_rst_rv",  32'(rvalid), 32'd0);
        check("mr_rst_gnt", 32'(gnt),    32'd0);
        @(posedge clk); #1;
        rst = 1'b0; req = 1'b0; rready = 1'b1;
        @(negedge clk); check("mr_post_rv0", 32'(rvalid), 32'd0);
        @(negedge clk); check("mr_post_rv1", 32'(rvalid), 32'd0);
        @(posedge clk); #1;
        xact(1'b0, Base + 32'h1C, 4'hF, 32'h0, 1'b0);
        get_rsp("mr_rd7", 32'h77, 1'b0, 1'b0, w);
        xact(1'b0, Base + 32'h14, 4'hF, 32'h0, 1'b1);
        get_rsp("mr_rd5", 32'h99, 1'b1, 1'b0, w);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
